// File: rtl/note_sequencer.sv
// Song-table note sequencer: plays table entries as timed notes for a downstream tone generator.
// Define NOTE_GAP_EN to insert GAP_CYCLES of silence between notes; otherwise notes run back-to-back.
module note_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12500000,
    parameter int unsigned GAP_CYCLES  = 1250000,
    parameter int unsigned SONG_LEN    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [19:0] wr_data,
    output logic [14:0] note_value,
    output logic        note_enable,
    output logic [4:0]  note_index,
    output logic        busy,
    output logic        song_done
);

    localparam int unsigned AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int unsigned PW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(BEAT_CYCLES - 1);
    localparam logic [4:0]    LAST_IDX   = 5'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
`ifdef NOTE_GAP_EN
        S_GAP,
`endif
        S_DONE
    } state_t;

    logic [19:0]   r_table [SONG_LEN];
    state_t        r_state;
    state_t        w_next;
    logic [4:0]    r_index;
    logic [19:0]   r_entry;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_beats;
    logic [19:0]   w_rd;
    logic          w_last;
    logic          w_play_end;

`ifdef NOTE_GAP_EN
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GW-1:0] r_gap;
    logic          w_gap_end;
    assign w_gap_end = (r_gap == GW'(GAP_CYCLES - 1));
`else
    logic w_unused_gap;
    assign w_unused_gap = (GAP_CYCLES != 0);
`endif

    // Table is only writable while idle; no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en && !reset && r_state == S_IDLE)
            r_table[wr_addr[AW-1:0]] <= wr_data;
    end

    assign w_rd       = r_table[r_index[AW-1:0]];
    assign w_last     = (r_index == LAST_IDX);
    assign w_play_end = (r_presc == PRESC_LAST) && (r_beats == r_entry[19:16] - 4'd1);

    always_comb begin
        w_next      = r_state;
        busy        = (r_state != S_IDLE);
        song_done   = (r_state == S_DONE);
        note_enable = (r_state == S_PLAY) && !r_entry[15];
        note_value  = r_entry[14:0];
        note_index  = r_index;
        case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: w_next = (w_rd[19:16] == 4'd0) ? S_DONE : S_PLAY;
            S_PLAY: begin
                if (w_play_end) begin
`ifdef NOTE_GAP_EN
                    w_next = S_GAP;
`else
                    w_next = w_last ? S_DONE : S_LOAD;
`endif
                end
            end
`ifdef NOTE_GAP_EN
            S_GAP: if (w_gap_end) w_next = w_last ? S_DONE : S_LOAD;
`endif
            S_DONE: w_next = loop ? S_LOAD : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (stop) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_entry <= '0;
            r_presc <= '0;
            r_beats <= '0;
`ifdef NOTE_GAP_EN
            r_gap   <= '0;
`endif
        end else begin
            r_state <= w_next;
            // Entering LOAD from IDLE/DONE restarts the song; from a note it advances.
            if (w_next == S_LOAD)
                r_index <= (r_state == S_IDLE || r_state == S_DONE) ? '0 : r_index + 5'd1;
            if (r_state == S_LOAD)
                r_entry <= w_rd;
            if (r_state == S_PLAY && w_next == S_PLAY) begin
                if (r_presc == PRESC_LAST) begin
                    r_presc <= '0;
                    r_beats <= r_beats + 4'd1;
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end else begin
                r_presc <= '0;
                r_beats <= '0;
            end
`ifdef NOTE_GAP_EN
            if (r_state == S_GAP && w_next == S_GAP)
                r_gap <= r_gap + GW'(1);
            else
                r_gap <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a song-level model expands the table into per-cycle expectations,
// applied together with directed vectors, hand sequences and randomized songs.
module tb_note_sequencer;

    localparam int BEAT = 4;
    localparam int GAPL = 2;
    localparam int SLEN = 32;
`ifdef NOTE_GAP_EN
    localparam int GAPC = GAPL;
`else
    localparam int GAPC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [19:0] wr_data = '0;
    logic [14:0] note_value;
    logic        note_enable;
    logic [4:0]  note_index;
    logic        busy;
    logic        song_done;

    note_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAPL),
        .SONG_LEN   (SLEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .note_value (note_value),
        .note_enable(note_enable),
        .note_index (note_index),
        .busy       (busy),
        .song_done  (song_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          start;
        bit          stop;
        bit          lp;
        bit          we;
        logic [4:0]  wa;
        logic [19:0] wd;
        bit          busy;
        bit          en;
        bit          done;
        bit          ci;
        logic [4:0]  idx;
        bit          cv;
        logic [14:0] val;
    } vec_t;

    vec_t        vq[$];
    logic [19:0] m_tab [SLEN];
    int          checks = 0;
    int          failures = 0;

    function automatic vec_t mk(input bit b, input bit en, input bit dn, input bit ci,
                                input logic [4:0] ix, input bit cv, input logic [14:0] vl);
        vec_t v;
        v.start = 0; v.stop = 0; v.lp = 0; v.we = 0; v.wa = '0; v.wd = '0;
        v.busy = b; v.en = en; v.done = dn; v.ci = ci; v.idx = ix; v.cv = cv; v.val = vl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vecs(input string tag, input int lim);
        vec_t v;
        int n;
        n = (lim < 0 || lim > vq.size()) ? vq.size() : lim;
        for (int i = 0; i < n; i++) begin
            v = vq[i];
            start = v.start; stop = v.stop; loop = v.lp;
            wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
            @(posedge clk); #1;
            check($sformatf("%s[%0d].busy_en_done", tag, i),
                  {29'd0, busy, note_enable, song_done}, {29'd0, v.busy, v.en, v.done});
            if (v.ci) check($sformatf("%s[%0d].index", tag, i), 32'(note_index), 32'(v.idx));
            if (v.cv) check($sformatf("%s[%0d].value", tag, i), 32'(note_value), 32'(v.val));
        end
        start = 0; stop = 0; loop = 0; wr_en = 0;
        vq.delete();
    endtask

    task automatic gen_write(input logic [4:0] a, input logic [19:0] d);
        vec_t v;
        v = mk(0, 0, 0, 0, '0, 0, '0);
        v.we = 1; v.wa = a; v.wd = d;
        m_tab[a] = d;
        vq.push_back(v);
    endtask

    // Expand the song from the model table into expected per-cycle outputs.
    task automatic gen_play(input bit lp, input int stop_at, input bit we0,
                            input logic [4:0] wa0, input logic [19:0] wd0);
        vec_t t[$];
        vec_t s;
        int idx;
        bit fin;
        logic [19:0] e;
        idx = 0; fin = 0;
        if (we0) m_tab[wa0] = wd0;
        while (!fin) begin
            t.push_back(mk(1, 0, 0, 1, 5'(idx), 0, '0));
            e = m_tab[idx];
            if (e[19:16] != 4'd0) begin
                for (int c = 0; c < int'(e[19:16]) * BEAT; c++)
                    t.push_back(mk(1, !e[15], 0, 1, 5'(idx), 1, e[14:0]));
                for (int c = 0; c < GAPC; c++)
                    t.push_back(mk(1, 0, 0, 1, 5'(idx), 1, e[14:0]));
            end
            if (e[19:16] == 4'd0 || idx == SLEN - 1) begin
                t.push_back(mk(1, 0, 1, 1, 5'(idx), 0, '0));
                if (lp) idx = 0; else fin = 1;
            end else begin
                idx++;
            end
            if (lp && t.size() > stop_at) fin = 1;
        end
        if (!lp) t.push_back(mk(0, 0, 0, 0, '0, 0, '0));
        if (stop_at > 0 && stop_at < t.size()) begin
            while (t.size() > stop_at) t.delete(t.size() - 1);
            s = mk(0, 0, 0, 0, '0, 0, '0);
            s.stop = 1;
            t.push_back(s);
            t.push_back(mk(0, 0, 0, 0, '0, 0, '0));
        end
        for (int i = 0; i < t.size(); i++) t[i].lp = lp;
        t[0].start = 1; t[0].we = we0; t[0].wa = wa0; t[0].wd = wd0;
        for (int i = 0; i < t.size(); i++) vq.push_back(t[i]);
    endtask

    task automatic load_basic();
        gen_write(5'd0, {4'd2, 1'b0, 15'd28408});
        gen_write(5'd1, {4'd1, 1'b0, 15'd20408});
        gen_write(5'd2, 20'd0);
    endtask

    vec_t dir [6];

    initial begin
        int L;
        bit lp;
        int sa;

        dir[0] = mk(0, 0, 0, 1, 5'd0, 1, 15'd0);
        dir[1] = mk(0, 0, 0, 1, 5'd0, 1, 15'd0); dir[1].start = 1; dir[1].stop = 1;
        dir[2] = mk(0, 0, 0, 1, 5'd0, 1, 15'd0);
        dir[3] = mk(0, 0, 0, 1, 5'd0, 1, 15'd0);
        dir[3].we = 1; dir[3].wa = 5'd0; dir[3].wd = {4'd1, 1'b1, 15'd100};
        dir[4] = mk(0, 0, 0, 1, 5'd0, 1, 15'd0);
        dir[4].we = 1; dir[4].wa = 5'd1; dir[4].wd = 20'd0;
        dir[5] = mk(0, 0, 0, 1, 5'd0, 1, 15'd0); dir[5].stop = 1;

        repeat (2) @(posedge clk);
        #1;
        check("reset.busy_en_done", {29'd0, busy, note_enable, song_done}, 32'd0);
        check("reset.index", 32'(note_index), 32'd0);
        check("reset.value", 32'(note_value), 32'd0);
        reset = 0;

        for (int i = 0; i < 6; i++) vq.push_back(dir[i]);
        run_vecs("directed", -1);
        m_tab[0] = {4'd1, 1'b1, 15'd100};
        m_tab[1] = 20'd0;

        gen_play(0, 0, 0, '0, '0);
        run_vecs("rest", -1);

        load_basic();
        run_vecs("basic_wr", -1);
        gen_play(0, 0, 0, '0, '0);
        run_vecs("basic", -1);

        gen_play(0, 0, 0, '0, '0);
        vq[4].start = 1; vq[4].we = 1; vq[4].wa = 5'd1; vq[4].wd = 20'hFFFFF;
        vq[5].start = 1;
        run_vecs("ignored", -1);
        gen_play(0, 0, 0, '0, '0);
        run_vecs("after_ignored", -1);

        gen_play(1, 25, 0, '0, '0);
        run_vecs("loop_stop", -1);

        gen_play(0, 0, 1, 5'd0, {4'd1, 1'b0, 15'd555});
        run_vecs("write_start", -1);
        gen_write(5'd0, {4'd2, 1'b0, 15'd28408});
        run_vecs("restore", -1);

        gen_play(0, 0, 0, '0, '0);
        run_vecs("pre_reset", 5);
        reset = 1;
        @(posedge clk); #1;
        check("midreset.busy_en_done", {29'd0, busy, note_enable, song_done}, 32'd0);
        check("midreset.index", 32'(note_index), 32'd0);
        check("midreset.value", 32'(note_value), 32'd0);
        reset = 0;
        gen_play(0, 0, 0, '0, '0);
        run_vecs("post_reset", -1);

        for (int r = 0; r < 12; r++) begin
            L = $urandom_range(1, 5);
            for (int k = 0; k < L; k++)
                gen_write(5'(k), {4'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0), 15'($urandom)});
            gen_write(5'(L), {4'd0, 1'b0, 15'($urandom)});
            lp = ($urandom_range(0, 2) == 0);
            if (lp) sa = $urandom_range(20, 60);
            else sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
            gen_play(lp, sa, 0, '0, '0);
            run_vecs($sformatf("rand%0d", r), -1);
        end

        for (int i = 0; i < SLEN; i++) gen_write(5'(i), {4'd1, 1'b0, 15'(1000 + i)});
        run_vecs("full_wr", -1);
        gen_play(0, 0, 0, '0, '0);
        run_vecs("full", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have these parameters: BEAT_CYCLES, default 12500000, clocks per beat; GAP_CYCLES, default 1250000, silent clocks between notes; SONG_LEN, default 32, song table depth (power of two, max 32).
REQ-002 The block SHALL have these ports, clock and reset first, with one clock and a synchronous active-high reset:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin playback from entry 0.
- stop  in  1  abort playback.
- loop  in  1  at end of song, restart from entry 0.
- wr_en  in  1  song table write strobe.
- wr_addr  in  5  table write address.
- wr_data  in  20  table entry: [19:16] duration in beats, where 0 marks end of song; [15] rest flag; [14:0] half-period count.
- note_value  out  15  half-period count sent to the downstream tone generator.
- note_enable  out  1  tone generator enable.
- note_index  out  5  entry currently playing.
- busy  out  1  high in any state except IDLE.
- song_done  out  1  one-cycle pulse at song end.

Function
REQ-003 Song table SHALL be SONG_LEN x 20-bit RAM, written on wr_en only in IDLE; writes in other states SHALL be ignored.
REQ-004 FSM states SHALL be IDLE, LOAD, PLAY, GAP, DONE.
REQ-005 IDLE: start high -> LOAD with note_index=0.
REQ-006 LOAD (one cycle): the entry at note_index SHALL be registered.
  - Duration 0 -> DONE.
  - Otherwise -> PLAY.
REQ-007 PLAY: note_value SHALL equal entry[14:0] and note_enable SHALL equal NOT entry[15].
  - Duration is held for exactly duration*BEAT_CYCLES cycles, counted by a beat prescaler plus a 4-bit beat counter.
  - Both counters are cleared on entry to PLAY.
REQ-008 PLAY end -> GAP (see REQ-017).
REQ-009 GAP: note_enable=0 and note_value held, for GAP_CYCLES cycles.
  - Then, if note_index = SONG_LEN-1 -> DONE.
  - Otherwise note_index+1 -> LOAD.
REQ-010 DONE (one cycle): song_done=1.
  - loop high -> note_index=0, LOAD.
  - Otherwise -> IDLE.
REQ-011 Latency: start sampled in IDLE at cycle N -> LOAD at N+1 -> note_enable valid at N+2.
REQ-012 stop high in any state SHALL force IDLE the next cycle.
  - note_enable=0, busy=0; song_done is not asserted.
  - stop takes priority over start in the same cycle.
REQ-013 start outside IDLE SHALL be ignored.
REQ-014 wr_en and start together in IDLE: the write SHALL complete and playback SHALL start; LOAD reads the newly written data.
REQ-015 note_index SHALL never exceed SONG_LEN-1 and SHALL NOT wrap; the last entry ends the song.

Reset
REQ-016 On reset, regardless of state, the block SHALL enter IDLE the next cycle with:
  - note_value=0, note_enable=0, note_index=0, busy=0, song_done=0.
  - All counters at 0.
  - Table contents unchanged (undefined after power-up).

Configuration
REQ-017 Macro NOTE_GAP_EN SHALL select the inter-note gap:
  - Defined: GAP state is implemented per REQ-009.
  - Undefined: GAP state is absent, GAP_CYCLES is unused, and PLAY end applies REQ-009's next-state rule directly with no silent cycles, so consecutive notes are back-to-back.

Verification
REQ-018 Bench parameters SHALL be BEAT_CYCLES=4, GAP_CYCLES=2, SONG_LEN=32, NOTE_GAP_EN defined unless stated.
REQ-019 Scenarios:
- Basic: table {0:(2,0,28408), 1:(1,0,20408), 2:(0,0,0)}, pulse start -> note_value=28408, enable high 8 cycles; 2 low; 20408 high 4 cycles; 2 low; song_done pulse; IDLE.
- Rest: entry 0=(1,1,100), entry 1=(0,0,0) -> note_enable stays 0 through 4 PLAY cycles; note_value=100.
- Loop: basic table with loop=1 -> after song_done, note_index=0 and 28408 plays again; stop -> IDLE next cycle, no song_done.
- Full table: all 32 entries duration 1 -> song_done after entry 31, note_index never 0 mid-song.
- Ignored inputs: wr_en to addr 1 during PLAY and start during PLAY -> table and playback unaffected; start+stop in IDLE -> stays IDLE.
- Reset mid-PLAY and no-gap build: reset mid-PLAY -> all outputs 0 next cycle; with NOTE_GAP_EN undefined, basic table -> 28408 for 8 cycles, then 20408 for 4 cycles, enable never drops between notes.
